riscv_core_branch_predictor: RTL

RISCV_CORE_BRANCH_PREDICTOR -- requirements
Module: riscv_core_branch_predictor

---
 rtl/riscv_core_branch_predictor_if.sv | 28 ++
 rtl/riscv_core_branch_predictor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/riscv_core_branch_predictor_if.sv
// Fetch-lookup and execute-update signal bundle for riscv_core_branch_predictor.
// The predictor takes the slave modport; the fetch/execute side takes master.
interface riscv_core_branch_predictor_if #(
    parameter int unsigned ALEN = 64
);
    logic [ALEN-1:0] i_fetch_pc;
    logic            o_valid;
    logic            o_branch_taken;
    logic [ALEN-1:0] o_target_address;
    logic            i_upd_en;
    logic [ALEN-1:0] i_upd_pc;
    logic            i_upd_branch;
    logic            i_upd_jump;
    logic            i_upd_taken;
    logic [ALEN-1:0] i_upd_target;

    modport slave (
        input  i_fetch_pc, i_upd_en, i_upd_pc, i_upd_branch, i_upd_jump, i_upd_taken,
               i_upd_target,
        output o_valid, o_branch_taken, o_target_address
    );

    modport master (
        output i_fetch_pc, i_upd_en, i_upd_pc, i_upd_branch, i_upd_jump, i_upd_taken,
               i_upd_target,
        input  o_valid, o_branch_taken, o_target_address
    );
endinterface

// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and zero-latency lookup.
// Define BP_GSHARE_EN to move counters into a GHR-xor-indexed gshare table.
module riscv_core_branch_predictor #(
    parameter int unsigned ALEN    = 64,
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned TAG_W   = 16
) (
    input logic                         i_clk,
    input logic                         i_rst_n,
    riscv_core_branch_predictor_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    typedef logic [IDX_W-1:0] idx_t;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] is_jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ALEN-1:0]    target_q [ENTRIES];
    // Per-entry counters, or the gshare pattern table when BP_GSHARE_EN is defined.
    logic [1:0]         ctr_q    [ENTRIES];

    idx_t             fetch_idx, fetch_cidx, upd_idx, upd_cidx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    logic             fetch_hit, upd_ok, upd_hit, wr_entry, ctr_we;
    logic [1:0]       ctr_cur, ctr_d;

    assign fetch_idx = bp.i_fetch_pc[IDX_W:1];
    assign fetch_tag = bp.i_fetch_pc[IDX_W+TAG_W:IDX_W+1];
    assign upd_idx   = bp.i_upd_pc[IDX_W:1];
    assign upd_tag   = bp.i_upd_pc[IDX_W+TAG_W:IDX_W+1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.i_fetch_pc[ALEN-1:IDX_W+TAG_W+1], bp.i_fetch_pc[0],
                              bp.i_upd_pc[ALEN-1:IDX_W+TAG_W+1], bp.i_upd_pc[0]};

`ifdef BP_GSHARE_EN
    idx_t ghr_q, ghr_d;

    assign fetch_cidx = fetch_idx ^ ghr_q;
    assign upd_cidx   = upd_idx ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_ok && bp.i_upd_branch) begin
            ghr_d = {ghr_q[IDX_W-2:0], bp.i_upd_taken};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign fetch_cidx = fetch_idx;
    assign upd_cidx   = upd_idx;
`endif

    // Lookup reads registered state only: a same-cycle update is not bypassed.
    assign fetch_hit           = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign bp.o_valid          = fetch_hit;
    assign bp.o_branch_taken   = fetch_hit && (is_jump_q[fetch_idx] || ctr_q[fetch_cidx][1]);
    assign bp.o_target_address = fetch_hit ? target_q[fetch_idx] : '0;

    assign upd_ok  = bp.i_upd_en && (bp.i_upd_branch ^ bp.i_upd_jump);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign ctr_cur = ctr_q[upd_cidx];

    always_comb begin
        wr_entry = 1'b0;
        ctr_we   = 1'b0;
        ctr_d    = ctr_cur;
        if (upd_ok) begin
            if (bp.i_upd_jump) begin
                wr_entry = 1'b1;
                ctr_we   = 1'b1;
                ctr_d    = 2'b11;
            end else if (bp.i_upd_taken) begin
                // Taken branch: allocate on miss, strengthen and retarget on hit.
                wr_entry = 1'b1;
                ctr_we   = 1'b1;
                if (!upd_hit) begin
                    ctr_d = 2'b10;
                end else if (ctr_cur != 2'b11) begin
                    ctr_d = ctr_cur + 2'd1;
                end
            end else if (upd_hit) begin
                ctr_we = 1'b1;
                if (ctr_cur != 2'b00) begin
                    ctr_d = ctr_cur - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= '0;
            is_jump_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (wr_entry) begin
                valid_q[upd_idx]   <= 1'b1;
                is_jump_q[upd_idx] <= bp.i_upd_jump;
            end
            if (ctr_we) begin
                ctr_q[upd_cidx] <= ctr_d;
            end
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (wr_entry) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bp.i_upd_target;
        end
    end
endmodule
